// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states, ALU ops,
// datapath mux selects and opcodes.
package mcpu_pkg;

    typedef enum logic [3:0] {
        StIf   = 4'd0,
        StId   = 4'd1,
        StMa   = 4'd2,
        StMrd  = 4'd3,
        StMwr  = 4'd4,
        StLwb  = 4'd5,
        StExr  = 4'd6,
        StExi  = 4'd7,
        StAwb  = 4'd8,
        StBr   = 4'd9,
        StJal  = 4'd10,
        StJalr = 4'd11,
        StIll  = 4'd12
    } state_e;

    // Selects how the ALU decoder interprets the function fields.
    typedef enum logic [1:0] {
        AluClsAdd = 2'd0,
        AluClsSub = 2'd1,
        AluClsR   = 2'd2,
        AluClsI   = 2'd3
    } alu_cls_e;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluXor = 3'b011;
    localparam logic [2:0] AluSrl = 3'b101;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

    localparam logic [1:0] SrcARs1   = 2'b00;
    localparam logic [1:0] SrcAPc    = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    localparam logic [4:0] OpR      = 5'b01100;
    localparam logic [4:0] OpI      = 5'b00100;
    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpJalr   = 5'b11001;

    function automatic state_e decode_op(input logic [4:0] op);
        state_e st;
        unique case (op)
            OpR:              st = StExr;
            OpI:              st = StExi;
            OpLoad, OpStore:  st = StMa;
            OpBranch:         st = StBr;
            OpJal:            st = StJal;
            OpJalr:           st = StJalr;
            default:          st = StIll;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// Maps an ALU usage class plus the instruction function fields to an ALU opcode.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [1:0] cls_i,
    input  logic [2:0] fun3_i,
    input  logic       fun7_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        unique case (alu_cls_e'(cls_i))
            AluClsAdd: alu_control_o = AluAdd;
            AluClsSub: alu_control_o = AluSub;
            AluClsR: begin
                case ({fun3_i, fun7_i})
                    4'b0000: alu_control_o = AluAdd;
                    4'b0001: alu_control_o = AluSub;
                    4'b1110: alu_control_o = AluAnd;
                    4'b1100: alu_control_o = AluOr;
                    4'b1000: alu_control_o = AluXor;
                    4'b0100: alu_control_o = AluSlt;
                    4'b1010: alu_control_o = AluSrl;
                    default: alu_control_o = AluAdd;
                endcase
            end
            AluClsI: begin
                // Fun7 is ignored: immediate shifts only support srl here.
                case (fun3_i)
                    3'b000:  alu_control_o = AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b100:  alu_control_o = AluXor;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    3'b101:  alu_control_o = AluSrl;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle control FSM: walks the shared datapath through fetch, decode,
// execute, memory and write-back, stalling memory stages on MIO_ready.
module mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       CPU_MIO,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSel,
    output logic [2:0] ALU_Control,
    output logic [3:0] state,
    output logic       illegal
);

    state_e   state_q, state_d;
    alu_cls_e alu_cls;
    logic [2:0] alu_ctrl;
    logic       branch_taken;

    logic       cpu_mio_c, mem_rw_c, iord_c, ir_write_c, pc_write_c, pc_write_cond_c;
    logic       pc_source_c, reg_write_c, illegal_c;
    logic [1:0] mem_to_reg_c, alu_src_a_c, alu_src_b_c, imm_sel_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = StIf;
        alu_cls         = AluClsAdd;
        cpu_mio_c       = 1'b0;
        mem_rw_c        = 1'b0;
        iord_c          = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pc_source_c     = 1'b0;
        reg_write_c     = 1'b0;
        illegal_c       = 1'b0;
        mem_to_reg_c    = WbAluOut;
        alu_src_a_c     = SrcARs1;
        alu_src_b_c     = SrcBRs2;
        imm_sel_c       = ImmI;

        unique case (state_q)
            StIf: begin
                cpu_mio_c   = 1'b1;
                alu_src_a_c = SrcAPc;
                alu_src_b_c = SrcBFour;
                ir_write_c  = MIO_ready;
                pc_write_c  = MIO_ready;
                state_d     = MIO_ready ? StId : StIf;
            end
            StId: begin
                // Speculative OldPC + imm so branch/JAL targets sit in ALUOut.
                alu_src_a_c = SrcAOldPc;
                alu_src_b_c = SrcBImm;
                imm_sel_c   = (OPcode == OpJal) ? ImmJ : ImmB;
                state_d     = decode_op(OPcode);
            end
            StMa: begin
                alu_src_b_c = SrcBImm;
                imm_sel_c   = (OPcode == OpLoad) ? ImmI : ImmS;
                state_d     = (OPcode == OpLoad) ? StMrd : StMwr;
            end
            StMrd: begin
                cpu_mio_c = 1'b1;
                iord_c    = 1'b1;
                state_d   = MIO_ready ? StLwb : StMrd;
            end
            StMwr: begin
                cpu_mio_c = 1'b1;
                iord_c    = 1'b1;
                mem_rw_c  = 1'b1;
                state_d   = MIO_ready ? StIf : StMwr;
            end
            StLwb: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = WbMdr;
            end
            StExr: begin
                alu_cls = AluClsR;
                state_d = StAwb;
            end
            StExi: begin
                alu_cls     = AluClsI;
                alu_src_b_c = SrcBImm;
                state_d     = StAwb;
            end
            StAwb: begin
                reg_write_c = 1'b1;
            end
            StBr: begin
                alu_cls         = AluClsSub;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 1'b1;
            end
            StJal: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = WbPc;
                pc_write_c   = 1'b1;
                pc_source_c  = 1'b1;
            end
            StJalr: begin
                alu_src_b_c  = SrcBImm;
                pc_write_c   = 1'b1;
                reg_write_c  = 1'b1;
                mem_to_reg_c = WbPc;
            end
            StIll: begin
                illegal_c = 1'b1;
            end
            default: state_d = StIf;
        endcase
    end

    mcpu_alu_dec u_alu_dec (
        .cls_i         (alu_cls),
        .fun3_i        (Fun3),
        .fun7_i        (Fun7),
        .alu_control_o (alu_ctrl)
    );

    assign branch_taken = rst_n && (state_q == StBr) &&
                          (((Fun3 == 3'b000) && zero) || ((Fun3 == 3'b001) && !zero));

    // Reset masks every output combinationally so an in-flight access aborts at once.
    assign CPU_MIO     = rst_n & cpu_mio_c;
    assign MemRW       = rst_n & mem_rw_c;
    assign IorD        = rst_n & iord_c;
    assign IRWrite     = rst_n & ir_write_c;
    assign PCWrite     = rst_n & pc_write_c;
    assign PCWriteCond = rst_n & pc_write_cond_c;
    assign PCSource    = rst_n & pc_source_c;
    assign RegWrite    = rst_n & reg_write_c;
    assign illegal     = rst_n & illegal_c;
    assign MemtoReg    = rst_n ? mem_to_reg_c : 2'b00;
    assign ALUSrcA     = rst_n ? alu_src_a_c : 2'b00;
    assign ALUSrcB     = rst_n ? alu_src_b_c : 2'b00;
    assign ImmSel      = rst_n ? imm_sel_c : 2'b00;
    assign ALU_Control = rst_n ? alu_ctrl : 3'b000;
    assign state       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: walks each instruction class through its states
// and checks outputs against hand-computed values.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       zero;
    logic       MIO_ready;
    logic       CPU_MIO, MemRW, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, RegWrite;
    logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ImmSel;
    logic [2:0] ALU_Control;
    logic [3:0] state;
    logic       illegal;
    logic [23:0] outs;
    logic [4:0]  wr_en;

    int n_cmp = 0;
    int n_fail = 0;

    mcpu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .OPcode      (OPcode),
        .Fun3        (Fun3),
        .Fun7        (Fun7),
        .zero        (zero),
        .MIO_ready   (MIO_ready),
        .CPU_MIO     (CPU_MIO),
        .MemRW       (MemRW),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ImmSel      (ImmSel),
        .ALU_Control (ALU_Control),
        .state       (state),
        .illegal     (illegal)
    );

    always #20 clk = ~clk;

    assign outs  = {CPU_MIO, MemRW, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, RegWrite,
                    MemtoReg, ALUSrcA, ALUSrcB, ImmSel, ALU_Control, state, illegal};
    assign wr_en = {RegWrite, PCWrite, PCWriteCond, IRWrite, MemRW};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] r_tab [8];
    logic [5:0] i_tab [7];

    initial begin
        // {Fun3, Fun7, expected ALU_Control}
        r_tab[0] = {3'b000, 1'b1, 3'b110};
        r_tab[1] = {3'b111, 1'b0, 3'b000};
        r_tab[2] = {3'b110, 1'b0, 3'b001};
        r_tab[3] = {3'b100, 1'b0, 3'b011};
        r_tab[4] = {3'b010, 1'b0, 3'b111};
        r_tab[5] = {3'b101, 1'b0, 3'b101};
        r_tab[6] = {3'b011, 1'b0, 3'b010};
        r_tab[7] = {3'b101, 1'b1, 3'b010};
        // {Fun3, expected ALU_Control}
        i_tab[0] = {3'b000, 3'b010};
        i_tab[1] = {3'b010, 3'b111};
        i_tab[2] = {3'b110, 3'b001};
        i_tab[3] = {3'b111, 3'b000};
        i_tab[4] = {3'b101, 3'b101};
        i_tab[5] = {3'b001, 3'b010};
        i_tab[6] = {3'b100, 3'b011};

        rst_n = 1'b0; OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0;
        zero = 1'b0; MIO_ready = 1'b1;
        #5;
        chk("reset_outs", 32'(outs), 32'h0);
        tick();
        chk("reset_outs_edge", 32'(outs), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_req", 32'(CPU_MIO), 32'd1);

        // R-type add
        chk("r_if_irw", 32'(IRWrite), 32'd1);
        chk("r_if_pcw", 32'(PCWrite), 32'd1);
        chk("r_if_srcs", 32'({IorD, ALUSrcA, ALUSrcB, ALU_Control}), 32'({1'b0, 2'b01, 2'b01, 3'b010}));
        chk("r_if_rw", 32'(RegWrite), 32'd0);
        tick();
        chk("r_id_state", 32'(state), 32'd1);
        chk("r_id_ctl", 32'({ImmSel, ALUSrcA, ALUSrcB}), 32'({2'b10, 2'b10, 2'b10}));
        chk("r_id_rw", 32'(RegWrite), 32'd0);
        tick();
        chk("r_ex_state", 32'(state), 32'd6);
        chk("r_ex_alu", 32'(ALU_Control), 32'd2);
        chk("r_ex_rw", 32'(RegWrite), 32'd0);
        for (int i = 0; i < 8; i++) begin
            Fun3 = r_tab[i][6:4]; Fun7 = r_tab[i][3];
            #1;
            chk($sformatf("r_dec%0d", i), 32'(ALU_Control), 32'(r_tab[i][2:0]));
        end
        Fun3 = 3'b000; Fun7 = 1'b0;
        tick();
        chk("r_awb_state", 32'(state), 32'd8);
        chk("r_awb_wb", 32'({RegWrite, MemtoReg}), 32'({1'b1, 2'b00}));
        tick();
        chk("r_done", 32'(state), 32'd0);

        // I-type
        OPcode = 5'b00100; Fun3 = 3'b100;
        tick();
        tick();
        chk("i_ex_state", 32'(state), 32'd7);
        chk("i_ex_ctl", 32'({ALUSrcA, ALUSrcB, ImmSel, ALU_Control}),
            32'({2'b00, 2'b10, 2'b00, 3'b011}));
        Fun7 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            Fun3 = i_tab[i][5:3];
            #1;
            chk($sformatf("i_dec%0d", i), 32'(ALU_Control), 32'(i_tab[i][2:0]));
        end
        Fun7 = 1'b0; Fun3 = 3'b000;
        tick();
        chk("i_awb", 32'({state, RegWrite}), 32'({4'd8, 1'b1}));
        tick();

        // Load, with an IF stall and two MRD wait cycles
        OPcode = 5'b00000; MIO_ready = 1'b0;
        #1;
        chk("ld_if_stall", 32'({state, CPU_MIO, IRWrite, PCWrite}), 32'({4'd0, 1'b1, 1'b0, 1'b0}));
        tick();
        chk("ld_if_hold", 32'(state), 32'd0);
        MIO_ready = 1'b1;
        #1;
        chk("ld_if_go", 32'({IRWrite, PCWrite}), 32'b11);
        tick();
        chk("ld_id", 32'(state), 32'd1);
        tick();
        chk("ld_ma", 32'({state, ImmSel, ALUSrcA, ALUSrcB}), 32'({4'd2, 2'b00, 2'b00, 2'b10}));
        MIO_ready = 1'b0;
        tick();
        chk("ld_mrd1", 32'({state, CPU_MIO, IorD, MemRW}), 32'({4'd3, 3'b110}));
        tick();
        chk("ld_mrd2", 32'({state, CPU_MIO, IorD, MemRW}), 32'({4'd3, 3'b110}));
        tick();
        MIO_ready = 1'b1;
        #1;
        chk("ld_mrd3", 32'({state, CPU_MIO, IorD, MemRW}), 32'({4'd3, 3'b110}));
        tick();
        chk("ld_lwb", 32'({state, RegWrite, MemtoReg}), 32'({4'd5, 1'b1, 2'b01}));
        tick();
        chk("ld_done", 32'(state), 32'd0);

        // beq taken, then bne not taken, both with zero=1
        OPcode = 5'b11000; Fun3 = 3'b000; zero = 1'b1;
        tick();
        chk("beq_id_imm", 32'(ImmSel), 32'd2);
        tick();
        chk("beq_br", 32'({state, PCWriteCond, PCSource, ALU_Control}),
            32'({4'd9, 1'b1, 1'b1, 3'b110}));
        chk("beq_taken", 32'(dut.branch_taken), 32'd1);
        tick();
        chk("beq_done", 32'(state), 32'd0);
        Fun3 = 3'b001;
        tick();
        tick();
        chk("bne_br", 32'({state, PCWriteCond}), 32'({4'd9, 1'b1}));
        chk("bne_taken", 32'(dut.branch_taken), 32'd0);
        tick();

        // JAL
        OPcode = 5'b11011; Fun3 = 3'b000; zero = 1'b0;
        tick();
        chk("jal_id_imm", 32'(ImmSel), 32'd3);
        tick();
        chk("jal_ex", 32'({state, RegWrite, MemtoReg, PCWrite, PCSource}),
            32'({4'd10, 1'b1, 2'b10, 1'b1, 1'b1}));
        tick();
        chk("jal_done", 32'(state), 32'd0);

        // JALR
        OPcode = 5'b11001;
        tick();
        tick();
        chk("jalr_ex", 32'({state, RegWrite, MemtoReg, PCWrite, PCSource, ALUSrcB}),
            32'({4'd11, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10}));
        tick();

        // Illegal opcode
        OPcode = 5'b01101;
        tick();
        chk("ill_id_nopulse", 32'(illegal), 32'd0);
        tick();
        chk("ill_state", 32'({state, illegal}), 32'({4'd12, 1'b1}));
        chk("ill_nowr", 32'({wr_en, CPU_MIO}), 32'd0);
        tick();
        chk("ill_after", 32'({state, illegal}), 32'({4'd0, 1'b0}));

        // Store aborted by reset mid-MWR
        OPcode = 5'b01000;
        tick();
        tick();
        chk("st_ma_imm", 32'({state, ImmSel}), 32'({4'd2, 2'b01}));
        MIO_ready = 1'b0;
        tick();
        chk("st_mwr", 32'({state, CPU_MIO, IorD, MemRW}), 32'({4'd4, 3'b111}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("st_rst_outs", 32'(outs), 32'h0);
        tick();
        chk("st_rst_hold", 32'(outs), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("st_rel", 32'({state, CPU_MIO, MemRW}), 32'({4'd0, 1'b1, 1'b0}));
        MIO_ready = 1'b1;
        #1;
        chk("st_rel_fetch", 32'(IRWrite), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
# mcpu_ctrl

Multi-cycle control sequencer for the RV32I subset CPU. It replaces the single-cycle decoder with a Moore/Mealy FSM that walks the shared datapath through fetch, decode, execute, memory and write-back. A single ALU and a single unified memory port are reused across these cycles. Memory accesses are stalled on `MIO_ready`. The block sits between the instruction register (IR) fields and the datapath multiplexers, write enables and memory port.

## Interface
Parameters:
- none. All encodings live in the shared package.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `OPcode`  in  5  `IR[6:2]`.
- `Fun3`  in  3  `IR[14:12]`.
- `Fun7`  in  1  `IR[30]`.
- `zero`  in  1  ALU zero flag.
- `MIO_ready`  in  1  memory has completed the current request this cycle.
- `CPU_MIO`  out  1  memory request valid.
- `MemRW`  out  1  1 = write, 0 = read.
- `IorD`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  load IR and OldPC.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by the branch condition.
- `PCSource`  out  1  PC input: 0 = ALU result, 1 = ALUOut.
- `RegWrite`  out  1  register-file write enable.
- `MemtoReg`  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUSrcA`  out  2  ALU A input: 00 = rs1, 01 = PC, 10 = OldPC.
- `ALUSrcB`  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ImmSel`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALU_Control`  out  3  ALU operation: 000 and, 001 or, 010 add, 011 xor, 101 srl, 110 sub, 111 slt.
- `state`  out  4  current state, for debug.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
State encodings:
- IF=0, ID=1, MA=2, MRD=3, MWR=4, LWB=5, EXR=6, EXI=7, AWB=8, BR=9, JAL=10, JALR=11, ILL=12.

Per-state behaviour:
- IF
  - Outputs: `CPU_MIO`=1, `IorD`=0, `ALUSrcA`=01, `ALUSrcB`=01, add.
  - When `MIO_ready`=1: `IRWrite`=1, `PCWrite`=1, `PCSource`=0, then go to ID.
  - When `MIO_ready`=0: stay in IF with all write enables at 0.
- ID
  - ALU computes OldPC + imm into ALUOut: `ALUSrcA`=10, `ALUSrcB`=10, add.
  - `ImmSel`=11 when OPcode=11011, otherwise 10.
  - Next state by opcode: 01100→EXR, 00100→EXI, 00000/01000→MA, 11000→BR, 11011→JAL, 11001→JALR, anything else→ILL.
- MA
  - rs1 + imm, add; `ImmSel`=00 for loads, 01 for stores.
  - Go to MRD for a load, MWR for a store.
- MRD
  - `CPU_MIO`=1, `IorD`=1, `MemRW`=0.
  - Hold until `MIO_ready`=1, then go to LWB.
- MWR
  - `CPU_MIO`=1, `IorD`=1, `MemRW`=1.
  - Hold until `MIO_ready`=1, then go to IF.
- LWB: `RegWrite`=1, `MemtoReg`=01, then go to IF.
- EXR
  - rs1 op rs2; ALU decode uses {`Fun3`,`Fun7`}: 0000 add, 0001 sub, 1110 and, 1100 or, 1000 xor, 0100 slt, 1010 srl.
  - Go to AWB.
- EXI
  - rs1 op imm(I); ALU decode uses `Fun3`: 000 add, 010 slt, 100 xor, 110 or, 111 and, 101 srl.
  - Go to AWB.
- Unlisted function codes in EXR/EXI: drive add, no error flag.
- AWB: `RegWrite`=1, `MemtoReg`=00, then go to IF.
- BR
  - rs1 − rs2 (sub), `PCWriteCond`=1, `PCSource`=1.
  - Branch is taken when (`Fun3`=000 and `zero`) or (`Fun3`=001 and not `zero`); every other `Fun3` is not taken.
  - Go to IF.
- JAL: `RegWrite`=1, `MemtoReg`=10 (PC already holds the return address), `PCWrite`=1, `PCSource`=1, then go to IF.
- JALR
  - rs1 + imm(I), `PCWrite`=1, `PCSource`=0, `RegWrite`=1, `MemtoReg`=10.
  - Go to IF.
- ILL: `illegal`=1, no writes, then go to IF.
- Default for all outputs: 0, except `ALU_Control`=010.
- Any unreachable state code recovers to IF on the next edge.

## Timing
- Reset
  - While `rst_n`=0: state=IF and every output is forced to 0, `ALU_Control` included.
  - The first request is issued in the cycle after `rst_n` rises.
- `rst_n` falling mid-access drops `CPU_MIO` immediately, aborting any pending write; no write enable may glitch high.
- Outputs are combinational from the state. Only `IRWrite`, `PCWrite` and the stage advance in IF/MRD/MWR are additionally qualified by `MIO_ready` in the same cycle.
- Latency with zero wait states:
  - R/I type: 4 cycles (IF, ID, EX, AWB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR: 3 cycles.
- Each cycle `MIO_ready`=0 in IF, MRD or MWR adds exactly one cycle.
- `CPU_MIO` stays high and the address stays stable until the accepting cycle.
- `MIO_ready` asserted outside IF/MRD/MWR is ignored.

## Structure
- Package `mcpu_pkg`: state enum, ALU_Control codes, ImmSel codes, MemtoReg/ALUSrc select codes, opcode constants.
- Sub-module `mcpu_alu_dec`: combinational map from (ALU class, `Fun3`, `Fun7`) to `ALU_Control`, instantiated once.

## Test plan
- R-type add (OPcode 01100, Fun 0000), `MIO_ready`=1 always → states 0,1,6,8,0; `RegWrite`=1 only in AWB; `ALU_Control`=010 in EXR.
- Load with `MIO_ready` low for 2 cycles in MRD → states 0,1,2,3,3,3,5,0; `CPU_MIO`=1 and `IorD`=1 held through all three MRD cycles.
- beq with `zero`=1, then bne with `zero`=1 → `PCWriteCond`=1 in BR both times; DUT taken-flag is 1, then 0.
- JAL (11011) → `ImmSel`=11 in ID; JAL state drives `RegWrite`=1, `MemtoReg`=10, `PCWrite`=1, `PCSource`=1; 3 cycles total.
- Opcode 01101 → ILL with `illegal` pulse exactly 1 cycle, then IF, no writes.
- `rst_n` low during MWR with `MIO_ready`=0 → all outputs 0 immediately; after release state=IF and `CPU_MIO`=1 with `MemRW`=0.
